// File: rtl/memory_block_mover.sv
// Block copy / block fill engine driving a single-port memory.
// Copy moves one word per READ-LATCH-WRITE triple; fill writes one word per cycle.
module memory_block_mover #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 256,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDRESSWIDTH-1:0] src_address,
    input  logic [ADDRESSWIDTH-1:0] dst_address,
    input  logic [ADDRESSWIDTH:0]   length,
    input  logic [DATAWIDTH-1:0]    fill_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESSWIDTH-1:0] mem_address,
    output logic [DATAWIDTH-1:0]    mem_data_in,
    input  logic [DATAWIDTH-1:0]    mem_data_out,
    output logic                    mem_write_en,
    output logic                    mem_read_en
);

    localparam int LEN_W = ADDRESSWIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATADEPTH);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    state_t                  state, state_n;
    logic                    mode_q, mode_n;
    logic [ADDRESSWIDTH-1:0] src_q, src_n;
    logic [ADDRESSWIDTH-1:0] dst_q, dst_n;
    logic [LEN_W-1:0]        len_q, len_n;
    logic [LEN_W-1:0]        idx_q, idx_n;
    logic [LEN_W-1:0]        idx_inc;
    logic [LEN_W-1:0]        len_clamped;
    logic [DATAWIDTH-1:0]    fill_q, fill_n;
    logic [DATAWIDTH-1:0]    data_q, data_n;
    logic [ADDRESSWIDTH-1:0] addr_n;
    logic [DATAWIDTH-1:0]    wdata_n;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    assign idx_inc     = idx_q + LEN_W'(1);
    assign len_clamped = clamp_len(length);

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        idx_n   = idx_q;
        fill_n  = fill_q;
        data_n  = data_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_n = mode;
                    src_n  = src_address;
                    dst_n  = dst_address;
                    len_n  = len_clamped;
                    fill_n = fill_data;
                    idx_n  = '0;
                    if (len_clamped == '0) begin
                        state_n = DONE;
                    end else if (mode) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ: begin
                state_n = LATCH;
            end
            LATCH: begin
                data_n  = mem_data_out;
                state_n = WRITE;
            end
            WRITE: begin
                idx_n = idx_inc;
                if (idx_inc == len_q) begin
                    state_n = DONE;
                end else if (mode_q) begin
                    state_n = WRITE;
                end else begin
                    state_n = READ;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Memory-side outputs are registered from the upcoming state so they line up
    // with that state; address and data hold their last value when no strobe is up.
    always_comb begin
        addr_n  = mem_address;
        wdata_n = mem_data_in;
        if (state_n == READ) begin
            addr_n = src_n + idx_n[ADDRESSWIDTH-1:0];
        end else if (state_n == WRITE) begin
            addr_n  = dst_n + idx_n[ADDRESSWIDTH-1:0];
            wdata_n = mode_n ? fill_n : data_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            fill_q       <= '0;
            data_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else begin
            state        <= state_n;
            mode_q       <= mode_n;
            src_q        <= src_n;
            dst_q        <= dst_n;
            len_q        <= len_n;
            idx_q        <= idx_n;
            fill_q       <= fill_n;
            data_q       <= data_n;
            busy         <= (state_n == READ) || (state_n == LATCH) || (state_n == WRITE);
            done         <= (state_n == DONE);
            mem_read_en  <= (state_n == READ);
            mem_write_en <= (state_n == WRITE);
            mem_address  <= addr_n;
            mem_data_in  <= wdata_n;
        end
    end

endmodule

// File: tb/tb_memory_block_mover.sv
// Scoreboard bench for memory_block_mover: a reference model predicts every memory
// access and the final memory image; a negedge monitor checks what the DUT drives.
module tb_memory_block_mover;

    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_address;
    logic [AW-1:0] dst_address;
    logic [AW:0]   length;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_write_en;
    logic          mem_read_en;

    always #5 clk = ~clk;

    memory_block_mover #(
        .DATAWIDTH(DW),
        .DATADEPTH(DEPTH),
        .ADDRESSWIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .src_address(src_address),
        .dst_address(dst_address),
        .length(length),
        .fill_data(fill_data),
        .busy(busy),
        .done(done),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en)
    );

    // Memory core: registered read, write committed on the strobed edge.
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pl_all = 1'b0;

    always @(posedge clk) begin
        if (pl_all) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = ref_mem[a];
        end
        if (mem_read_en) mem_data_out <= mem[mem_address];
        if (mem_write_en) mem[mem_address] = mem_data_in;
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  rq[$];
    int  n_checks    = 0;
    int  n_fail      = 0;
    int  busy_cycles = 0;
    int  done_pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 'h%0h, required 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    wr_t mon_w;
    int  mon_a;
    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_exclusive", int'(mem_read_en & mem_write_en), 0);
            check("busy_done_exclusive", int'(busy & done), 0);
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            if (mem_read_en) begin
                check("read_expected", int'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    mon_a = rq.pop_front();
                    check("read_addr", int'(mem_address), mon_a);
                end
            end
            if (mem_write_en) begin
                check("write_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    mon_w = wq.pop_front();
                    check("write_addr", int'(mem_address), mon_w.addr);
                    check("write_data", int'(mem_data_in), mon_w.data);
                end
            end
        end
    end

    // Reference model: predicted accesses and memory effect of one operation.
    task automatic expect_op(input int m, input int src, input int dst, input int len,
                             input int fill, input int max_writes, output int exp_busy);
        int n;
        int a;
        int d;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            a = (dst + i) % DEPTH;
            d = (m == 1) ? fill : int'(ref_mem[(src + i) % DEPTH]);
            if (i < max_writes) begin
                if (m == 0) rq.push_back((src + i) % DEPTH);
                wq.push_back('{a, d});
            end
            if (i < max_writes - 1 || max_writes >= n) ref_mem[a] = d[DW-1:0];
        end
        exp_busy = (m == 1) ? n : 3 * n;
    endtask

    task automatic preload();
        @(negedge clk);
        pl_all = 1'b1;
        @(negedge clk);
        pl_all = 1'b0;
    endtask

    task automatic issue(input int m, input int src, input int dst, input int len, input int fill);
        @(negedge clk);
        mode        = m[0];
        src_address = src[AW-1:0];
        dst_address = dst[AW-1:0];
        length      = len[AW:0];
        fill_data   = fill[DW-1:0];
        busy_cycles = 0;
        done_pulses = 0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        mode        = 1'($urandom);
        src_address = AW'($urandom);
        dst_address = AW'($urandom);
        length      = (AW + 1)'($urandom);
        fill_data   = DW'($urandom);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy);
        int cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", int'(done), 1);
        check("done_latency", cyc, exp_lat);
        check("busy_in_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        @(negedge clk);
        check("busy_cycles", busy_cycles, exp_busy);
        check("done_pulses", done_pulses, 1);
        check("writes_left", wq.size(), 0);
        check("reads_left", rq.size(), 0);
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_mem[a]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_op(input int m, input int src, input int dst, input int len, input int fill);
        int eb;
        expect_op(m, src, dst, len, fill, DEPTH + 1, eb);
        issue(m, src, dst, len, fill);
        wait_done(eb, eb);
        mem_check("mem_image");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb;
        int m;
        int len;
        reset        = 1'b1;
        start        = 1'b0;
        mode         = 1'b0;
        src_address  = '0;
        dst_address  = '0;
        length       = '0;
        fill_data    = '0;
        mem_data_out = '0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = DW'($urandom);
        preload();
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(mem_write_en), 0);
        check("rst_re", int'(mem_read_en), 0);
        check("rst_addr", int'(mem_address), 0);
        check("rst_wdata", int'(mem_data_in), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill 0x10..0x13 with 0xA5
        run_op(1, 0, 'h10, 4, 'hA5);

        // Copy three preloaded words 0x20 -> 0x40
        ref_mem['h20] = 8'h11;
        ref_mem['h21] = 8'h22;
        ref_mem['h22] = 8'h33;
        preload();
        run_op(0, 'h20, 'h40, 3, 0);
        check("copy_w0", int'(mem['h40]), 'h11);
        check("copy_w1", int'(mem['h41]), 'h22);
        check("copy_w2", int'(mem['h42]), 'h33);

        // Zero length: done one cycle after start, nothing touched
        run_op(1, 'h30, 'h30, 0, 'h77);

        // Fill wrapping past the top of the address space
        run_op(1, 0, 'hFE, 4, 'h3C);

        // Overlapping copy propagates the first word
        run_op(0, 'h50, 'h51, 5, 0);

        // Length above depth clamps to a full-memory fill
        run_op(1, 0, 'h07, 300, 'h5A);

        // Second start while busy is ignored
        expect_op(0, 'h60, 'h90, 4, 0, DEPTH + 1, eb);
        issue(0, 'h60, 'h90, 4, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
        end
        mode        = 1'b1;
        dst_address = 8'h80;
        length      = 9'd8;
        fill_data   = 8'hEE;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(eb - 5, eb);
        repeat (10) @(negedge clk);
        check("idle_after_ignored_start", int'(busy), 0);
        mem_check("mem_image_busy_start");

        // Asynchronous reset during the second write of a five-word fill
        expect_op(1, 0, 'hC0, 5, 'h99, 2, eb);
        issue(1, 0, 'hC0, 5, 'h99);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("pre_reset_we", int'(mem_write_en), 1);
        reset = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_we", int'(mem_write_en), 0);
        check("arst_re", int'(mem_read_en), 0);
        check("arst_addr", int'(mem_address), 0);
        check("arst_wdata", int'(mem_data_in), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("arst_no_done", done_pulses, 0);
        check("arst_writes_left", wq.size(), 0);
        mem_check("mem_image_reset");
        run_op(1, 0, 'hC8, 3, 'h42);

        // Randomized operations
        for (int t = 0; t < 24; t++) begin
            m   = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 300))
                                              : int'($urandom_range(0, 12));
            run_op(m, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), len,
                   int'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_block_mover.md
Name: memory_block_mover

Overview:
- Initiator-side engine that drives the memory_interface "out" direction: address, data_in, write_en and read_en out; data_out back in.
- On a start pulse it performs one of two operations on a single-port memory:
  - block copy: read source range, write destination range;
  - block fill: write a constant to the destination range.
- Sits between a control/CPU block and any memory core exposing the memory_interface "in" side. Used for buffer clears and buffer moves.

Parameters:
- DATAWIDTH, 8, memory word width in bits.
- DATADEPTH, 256, memory depth in words.
- ADDRESSWIDTH, $clog2(DATADEPTH), address width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; latched on accepted start.
- src_address  input  ADDRESSWIDTH  copy source base; latched on start.
- dst_address  input  ADDRESSWIDTH  destination base; latched on start.
- length  input  ADDRESSWIDTH+1  word count, 0..DATADEPTH; latched on start.
- fill_data  input  DATAWIDTH  fill value; latched on start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse on completion.
- mem_address  output  ADDRESSWIDTH  to memory address.
- mem_data_in  output  DATAWIDTH  write data to memory (memory data_in).
- mem_data_out  input  DATAWIDTH  read data from memory (memory data_out).
- mem_write_en  output  1  memory write strobe.
- mem_read_en  output  1  memory read strobe.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - busy, done, mem_write_en and mem_read_en go to 0;
  - mem_address and mem_data_in go to 0;
  - internal counters and latched parameters are cleared.
  - An operation in progress is abandoned with no done pulse.
- Memory timing: memory samples read_en/address on edge k; mem_data_out is valid throughout the cycle after edge k. The write is committed on the edge where write_en=1.
- States: IDLE, READ, LATCH, WRITE, DONE.
- IDLE:
  - All strobes are 0.
  - start=1 at an edge latches mode, src, dst, length and fill_data, and clears the word index i.
  - Next state:
    - length=0 → DONE;
    - mode=0 → READ;
    - mode=1 → WRITE.
- READ (copy only): mem_read_en=1, mem_address=src+i. Next state LATCH.
- LATCH: capture mem_data_out into a data register; no strobes. Next state WRITE.
- WRITE:
  - mem_write_en=1 and mem_address=dst+i.
  - mem_data_in = captured register in copy mode, fill_data in fill mode.
  - i increments.
  - Next state: DONE if i+1==length; otherwise READ (copy) or WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy=1 in READ, LATCH and WRITE; 0 in IDLE and DONE.
- Throughput: copy is 3 cycles/word, fill is 1 cycle/word.
  - Copy of N>0 words: busy high for exactly 3N cycles, then the done pulse.
  - Fill of N>0 words: busy high for exactly N cycles, then the done pulse.
- Address arithmetic is modulo 2^ADDRESSWIDTH: src+i and dst+i wrap silently. Length values above DATADEPTH are clamped to DATADEPTH at latch.
- mem_read_en and mem_write_en are never both 1 in the same cycle.
- start while busy or in DONE is ignored, not queued. A start held high across DONE is accepted in the following IDLE cycle.
- Copy proceeds in ascending address order. Overlapping ranges with dst>src produce propagated data; this is defined behaviour, not an error.
- mem_address and mem_data_in are don't-care when both strobes are 0. The implementation holds them at their last values.

Test Plan:
- Fill: mode=1, dst=0x10, length=4, fill_data=0xA5.
  - Required: mem_write_en high for 4 consecutive cycles at addresses 0x10..0x13, each with data 0xA5.
  - done pulses the cycle after the 4th write; mem_read_en never asserts.
- Copy: preload mem[0x20..0x22]=0x11,0x22,0x33; mode=0, src=0x20, dst=0x40, length=3.
  - Required: busy high for 9 cycles; mem[0x40..0x42]=0x11,0x22,0x33; single done pulse.
- Zero length: start with length=0.
  - Required: no read or write strobes; done=1 exactly one cycle after the start edge; busy stays 0.
- Wrap: fill with dst=0xFE, length=4, DATADEPTH=256.
  - Required: writes at 0xFE, 0xFF, 0x00, 0x01, and no other locations are modified.
- Start during busy: pulse start again mid-copy with different parameters.
  - Required: first operation completes unchanged, only one done pulse, second request is not executed.
- Reset mid-operation: assert reset asynchronously during the 2nd WRITE of a length-5 fill.
  - Required: all outputs are 0 immediately (before the next edge), no done pulse, and a new start after reset release runs normally.
